ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Pipelined control unit for the 5-stage core: decodes the ID-stage opcode and carries control through EX, MEM and WB stage registers.
- Also provides load-use hazard stall, branch flush, multi-cycle memory freeze, sticky HALT and illegal-opcode flags, and a saturating stall counter.
- Every decoded field has an explicit default, so no latched outputs are possible.

Parameters:
- OP_W, 5, opcode width; decode uses the top 5 bits, and any extra low bits are ignored.
- REG_W, 3, register index width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_op  in  OP_W  opcode
- id_rd, id_rs, id_rt  in  REG_W each  register fields
- flush  in  1  EX branch resolved taken; kill the ID instruction
- mem_ready  in  1  data memory completes the current access
- stall_if  out  1  fetch/ID must hold
- ex_valid, ex_alu_src, ex_pc_sel  out  1 each
- ex_alu_op  out  3
- ex_i_sel  out  2
- mem_valid  out  1
- mem_we  out  2  (00 none, 10 read, 11 write)
- wb_valid, wb_rf_we, wb_rev_sel  out  1 each
- wb_memreg  out  2
- wb_rd  out  REG_W
- halted  out  1
- illegal  out  1
- stall_cnt  out  CNT_W

Behaviour:
- Reset (rst=0, async) clears every stage register, halted, illegal and stall_cnt to 0; stall_if resets to 0.
- Decode defaults (combinational): rf_we=0, mem_we=00, alu_src=0, i_sel=00, memreg=11, rev_sel=0, pc_sel=1, reads_rs=0, reads_rt=0. alu_op is always op[2:0].
- Decode overrides:
  - 00000 HALT: pc_sel=0.
  - 00001 NOP: no overrides.
  - 0100x ADDI/SUBI: rf_we, alu_src, reads_rs.
  - 01010 XORI and 01011 ANDNI: same as ADDI/SUBI plus i_sel=01.
  - 101xx shift-imm: rf_we, alu_src, reads_rs.
  - 10000 ST: mem_we=11, alu_src, reads_rs, reads_rt.
  - 10001 LD: rf_we, mem_we=10, alu_src, memreg=00, reads_rs.
  - 10011 STU: rf_we, mem_we=11, alu_src, reads_rs, reads_rt.
  - 11001 BTR: rf_we, rev_sel, reads_rs.
  - 11011 ALU R-type: rf_we, reads_rs, reads_rt.
  - Any other opcode: treated as NOP and sets illegal (sticky) when admitted to EX.
- Latency: an instruction admitted at cycle n appears at EX in n+1, MEM in n+2 and WB in n+3.
- load_use (combinational): ex_valid & ex_mem_we==10 & id_valid & ((reads_rs & id_rs==ex_rd) | (reads_rt & id_rt==ex_rd)).
- freeze (combinational): mem_valid & mem_we!=00 & !mem_ready.
- Priority per cycle:
  - freeze: EX and MEM hold; WB loads a bubble (wb_valid=0); stall_if=1; flush is ignored, and its source holds it until freeze clears.
  - else flush: EX loads a bubble; the ID instruction is discarded; stall_if=0.
  - else load_use: EX loads a bubble; stall_if=1; MEM and WB advance.
  - else: normal advance.
- A bubble has valid=0 and all write enables 0. Downstream stages gate actions on *_valid.
- HALT: once a valid HALT enters EX, stall_if=1 permanently and no new instruction is admitted; older instructions drain. halted=1 when HALT is in WB and stays 1 until reset.
- stall_cnt increments by 1 for each freeze or load_use cycle, saturates at all-ones, and does not wrap.
- Reset mid-freeze: all state clears immediately; the pending memory access is abandoned.

Test Plan:
- Reset then ADDI (01000, rd=3): ex_valid=1 and ex_alu_src=1 at n+1; mem_we=00 at n+2; wb_rf_we=1, wb_rd=3, wb_memreg=11 at n+3.
- LD rd=2 followed by ADD with rs=2: one bubble (ex_valid=0), stall_if=1 for 1 cycle, stall_cnt=1. The ADD reaches WB 1 cycle late.
- ST with mem_ready low for 3 cycles: stall_if=1 and wb_valid=0 for 3 cycles, MEM holds mem_we=11, stall_cnt=3; then normal flow resumes.
- flush asserted with a valid SUBI in ID: ex_valid=0 next cycle, no register write, and the next fetched instruction is admitted the cycle after.
- Opcode 11111: illegal=1 after one cycle, wb_rf_we=0, and the pipeline continues.
- HALT followed by ADDI: ADDI is never admitted; halted=1 at n+3; stall_if remains 1. With CNT_W=2 and 5 stall cycles, stall_cnt saturates at 3.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: ID decode carried through EX/MEM/WB stage registers,
// with load-use stall, branch flush, memory freeze, halt and illegal tracking.
module ctrl_pipe #(
    parameter int OP_W  = 5,
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_op,
    input  logic [REG_W-1:0] id_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             ex_valid,
    output logic             ex_alu_src,
    output logic             ex_pc_sel,
    output logic [2:0]       ex_alu_op,
    output logic [1:0]       ex_i_sel,
    output logic             mem_valid,
    output logic [1:0]       mem_we,
    output logic             wb_valid,
    output logic             wb_rf_we,
    output logic             wb_rev_sel,
    output logic [1:0]       wb_memreg,
    output logic [REG_W-1:0] wb_rd,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic             halt;
        logic             rf_we;
        logic [1:0]       mem_we;
        logic             alu_src;
        logic [1:0]       i_sel;
        logic [1:0]       memreg;
        logic             rev_sel;
        logic             pc_sel;
        logic [2:0]       alu_op;
        logic [REG_W-1:0] rd;
    } ctl_t;

    ctl_t       dec, ex_in, ex_q, mem_q, wb_q;
    logic [4:0] op5;
    logic       reads_rs, reads_rt, bad;
    logic       load_use, freeze, admit, halt_pend;

    assign op5 = id_op[OP_W-1 -: 5];

    always_comb begin
        dec         = '0;
        dec.valid   = id_valid;
        dec.memreg  = 2'b11;
        dec.pc_sel  = 1'b1;
        dec.alu_op  = op5[2:0];
        dec.rd      = id_rd;
        reads_rs    = 1'b0;
        reads_rt    = 1'b0;
        bad         = 1'b0;
        unique case (1'b1)
            (op5 == 5'b00000): begin
                dec.pc_sel = 1'b0;
                dec.halt   = 1'b1;
            end
            (op5 == 5'b00001): begin
            end
            (op5[4:1] == 4'b0100): begin
                dec.rf_we   = 1'b1;
                dec.alu_src = 1'b1;
                reads_rs    = 1'b1;
            end
            (op5[4:1] == 4'b0101): begin
                dec.rf_we   = 1'b1;
                dec.alu_src = 1'b1;
                dec.i_sel   = 2'b01;
                reads_rs    = 1'b1;
            end
            (op5[4:2] == 3'b101): begin
                dec.rf_we   = 1'b1;
                dec.alu_src = 1'b1;
                reads_rs    = 1'b1;
            end
            (op5 == 5'b10000): begin
                dec.mem_we  = 2'b11;
                dec.alu_src = 1'b1;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
            end
            (op5 == 5'b10001): begin
                dec.rf_we   = 1'b1;
                dec.mem_we  = 2'b10;
                dec.alu_src = 1'b1;
                dec.memreg  = 2'b00;
                reads_rs    = 1'b1;
            end
            (op5 == 5'b10011): begin
                dec.rf_we   = 1'b1;
                dec.mem_we  = 2'b11;
                dec.alu_src = 1'b1;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
            end
            (op5 == 5'b11001): begin
                dec.rf_we   = 1'b1;
                dec.rev_sel = 1'b1;
                reads_rs    = 1'b1;
            end
            (op5 == 5'b11011): begin
                dec.rf_we = 1'b1;
                reads_rs  = 1'b1;
                reads_rt  = 1'b1;
            end
            default: bad = 1'b1;
        endcase
    end

    assign load_use = ex_q.valid && ex_q.mem_we == 2'b10 && id_valid &&
                      ((reads_rs && id_rs == ex_q.rd) ||
                       (reads_rt && id_rt == ex_q.rd));
    assign freeze   = mem_q.valid && mem_q.mem_we != 2'b00 && !mem_ready;
    assign admit    = id_valid && !halt_pend && !flush && !load_use;
    // a pending HALT blocks fetch for good, even across a flush
    assign stall_if = freeze || halt_pend || (load_use && !flush);

    always_comb begin
        ex_in = '0;
        if (admit) ex_in = dec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            halt_pend <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (freeze) begin
                wb_q <= '0;
            end else begin
                ex_q  <= ex_in;
                mem_q <= ex_q;
                wb_q  <= mem_q;
                if (admit && dec.halt) halt_pend <= 1'b1;
                if (admit && bad) illegal <= 1'b1;
                if (mem_q.valid && mem_q.halt) halted <= 1'b1;
            end
            if ((freeze || load_use) && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_alu_src = ex_q.alu_src;
    assign ex_pc_sel  = ex_q.pc_sel;
    assign ex_alu_op  = ex_q.alu_op;
    assign ex_i_sel   = ex_q.i_sel;
    assign mem_valid  = mem_q.valid;
    assign mem_we     = mem_q.mem_we;
    assign wb_valid   = wb_q.valid;
    assign wb_rf_we   = wb_q.rf_we;
    assign wb_rev_sel = wb_q.rev_sel;
    assign wb_memreg  = wb_q.memreg;
    assign wb_rd      = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: cycle model of stage occupancy plus a
// retire queue checked by a WB monitor; a CNT_W=2 twin checks saturation.
module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, flush, mem_ready;
    logic [4:0] id_op;
    logic [2:0] id_rd, id_rs, id_rt;

    logic        stall_if, ex_valid, ex_alu_src, ex_pc_sel, mem_valid;
    logic [2:0]  ex_alu_op;
    logic [1:0]  ex_i_sel, mem_we, wb_memreg;
    logic        wb_valid, wb_rf_we, wb_rev_sel, halted, illegal;
    logic [2:0]  wb_rd;
    logic [15:0] stall_cnt;

    logic        s_stall_if, s_ex_valid, s_ex_alu_src, s_ex_pc_sel, s_mem_valid;
    logic [2:0]  s_ex_alu_op;
    logic [1:0]  s_ex_i_sel, s_mem_we, s_wb_memreg;
    logic        s_wb_valid, s_wb_rf_we, s_wb_rev_sel, s_halted, s_illegal;
    logic [2:0]  s_wb_rd;
    logic [1:0]  s_stall_cnt;

    always #5 clk = ~clk;

    ctrl_pipe #(.OP_W(5), .REG_W(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
        .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
        .mem_ready(mem_ready), .stall_if(stall_if), .ex_valid(ex_valid),
        .ex_alu_src(ex_alu_src), .ex_pc_sel(ex_pc_sel), .ex_alu_op(ex_alu_op),
        .ex_i_sel(ex_i_sel), .mem_valid(mem_valid), .mem_we(mem_we),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_rev_sel(wb_rev_sel),
        .wb_memreg(wb_memreg), .wb_rd(wb_rd), .halted(halted),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    ctrl_pipe #(.OP_W(5), .REG_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
        .id_rd(id_rd), .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
        .mem_ready(mem_ready), .stall_if(s_stall_if), .ex_valid(s_ex_valid),
        .ex_alu_src(s_ex_alu_src), .ex_pc_sel(s_ex_pc_sel),
        .ex_alu_op(s_ex_alu_op), .ex_i_sel(s_ex_i_sel),
        .mem_valid(s_mem_valid), .mem_we(s_mem_we), .wb_valid(s_wb_valid),
        .wb_rf_we(s_wb_rf_we), .wb_rev_sel(s_wb_rev_sel),
        .wb_memreg(s_wb_memreg), .wb_rd(s_wb_rd), .halted(s_halted),
        .illegal(s_illegal), .stall_cnt(s_stall_cnt)
    );

    typedef struct packed {
        logic       v;
        logic [4:0] op;
        logic [2:0] rd;
    } slot_t;

    typedef struct packed {
        logic       rf_we;
        logic [1:0] we;
        logic       alu_src;
        logic [1:0] i_sel;
        logic [1:0] memreg;
        logic       rev;
        logic       pc_sel;
        logic       rs;
        logic       rt;
        logic       legal;
        logic       halt;
    } dec_t;

    // Opcode table, one line per instruction class
    function automatic dec_t decode(input logic [4:0] op);
        dec_t d;
        d = '0;
        d.memreg = 2'd3;
        d.pc_sel = 1'b1;
        d.legal  = 1'b1;
        casez (op)
            5'b00000: begin d.pc_sel = 0; d.halt = 1; end
            5'b00001: d.legal = 1'b1;
            5'b0100?: begin d.rf_we = 1; d.alu_src = 1; d.rs = 1; end
            5'b0101?: begin d.rf_we = 1; d.alu_src = 1; d.rs = 1; d.i_sel = 1; end
            5'b101??: begin d.rf_we = 1; d.alu_src = 1; d.rs = 1; end
            5'b10000: begin d.we = 3; d.alu_src = 1; d.rs = 1; d.rt = 1; end
            5'b10001: begin d.rf_we = 1; d.we = 2; d.alu_src = 1; d.memreg = 0; d.rs = 1; end
            5'b10011: begin d.rf_we = 1; d.we = 3; d.alu_src = 1; d.rs = 1; d.rt = 1; end
            5'b11001: begin d.rf_we = 1; d.rev = 1; d.rs = 1; end
            5'b11011: begin d.rf_we = 1; d.rs = 1; d.rt = 1; end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

    int    n_chk = 0;
    int    n_err = 0;
    slot_t sb[$];

    slot_t m_ex, m_mem, m_wb;
    bit    m_hs, m_ill, m_halted, m_frz, m_lu, m_admit;
    int    m_cnt;

    logic       n_v, n_fl, n_mr;
    logic [4:0] n_op;
    logic [2:0] n_rd, n_rs, n_rt;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // WB monitor: every retiring instruction must match the oldest admitted one
    always @(negedge clk) begin
        if (rst === 1'b1 && wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_retire", 1, 0);
            end else begin
                slot_t s;
                dec_t  d;
                s = sb.pop_front();
                d = decode(s.op);
                chk("wb_rf_we", 32'(wb_rf_we), 32'(d.rf_we));
                chk("wb_memreg", 32'(wb_memreg), 32'(d.memreg));
                chk("wb_rev_sel", 32'(wb_rev_sel), 32'(d.rev));
                chk("wb_rd", 32'(wb_rd), 32'(s.rd));
            end
        end
    end

    task automatic model_clear();
        m_ex = '0; m_mem = '0; m_wb = '0;
        m_hs = 0; m_ill = 0; m_halted = 0; m_cnt = 0;
        m_frz = 0; m_lu = 0; m_admit = 0;
        sb.delete();
    endtask

    task automatic check_reset_state();
        chk("rst_stall_if", 32'(stall_if), 0);
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_mem_valid", 32'(mem_valid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_rf_we", 32'(wb_rf_we), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_sat_cnt", 32'(s_stall_cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        id_valid = 0; flush = 0; mem_ready = 1;
        id_op = 0; id_rd = 0; id_rs = 0; id_rt = 0;
        n_v = 0; n_fl = 0; n_mr = 1; n_op = 0; n_rd = 0; n_rs = 0; n_rt = 0;
        #1;
        check_reset_state();
        model_clear();
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // One clock: drive, check combinational and staged state, then advance model
    task automatic cycle();
        dec_t di, de, dm;
        bit   exp_stall;
        @(negedge clk);
        id_valid = n_v; id_op = n_op; id_rd = n_rd; id_rs = n_rs; id_rt = n_rt;
        flush = n_fl; mem_ready = n_mr;
        #1;
        di = decode(id_op);
        de = decode(m_ex.op);
        dm = decode(m_mem.op);
        m_frz = m_mem.v && dm.we != 0 && !mem_ready;
        m_lu  = m_ex.v && de.we == 2 && id_valid &&
                ((di.rs && id_rs == m_ex.rd) || (di.rt && id_rt == m_ex.rd));
        exp_stall = m_frz || m_hs || (m_lu && !flush);
        chk("stall_if", 32'(stall_if), 32'(exp_stall));
        chk("ex_valid", 32'(ex_valid), 32'(m_ex.v));
        if (m_ex.v) begin
            chk("ex_alu_src", 32'(ex_alu_src), 32'(de.alu_src));
            chk("ex_pc_sel", 32'(ex_pc_sel), 32'(de.pc_sel));
            chk("ex_alu_op", 32'(ex_alu_op), 32'(m_ex.op[2:0]));
            chk("ex_i_sel", 32'(ex_i_sel), 32'(de.i_sel));
        end
        chk("mem_valid", 32'(mem_valid), 32'(m_mem.v));
        chk("mem_we", 32'(mem_we), m_mem.v ? 32'(dm.we) : 0);
        chk("wb_valid", 32'(wb_valid), 32'(m_wb.v));
        if (!m_wb.v) chk("wb_bubble_we", 32'(wb_rf_we), 0);
        chk("halted", 32'(halted), 32'(m_halted));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("sat_cnt", 32'(s_stall_cnt), (m_cnt > 3) ? 3 : m_cnt);
        @(posedge clk);
        m_admit = 0;
        if (m_frz) begin
            m_wb = '0;
        end else begin
            if (m_mem.v && dm.halt) m_halted = 1;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_admit = id_valid && !m_hs && !flush && !m_lu;
            m_ex = '0;
            if (m_admit) begin
                m_ex = '{v: 1'b1, op: id_op, rd: id_rd};
                sb.push_back(m_ex);
                if (di.halt) m_hs = 1;
                if (!di.legal) m_ill = 1;
            end
        end
        if ((m_frz || m_lu) && m_cnt < 65535) m_cnt++;
    endtask

    task automatic set_id(input logic [4:0] op, input logic [2:0] rd,
                          input logic [2:0] rs, input logic [2:0] rt);
        n_v = 1; n_op = op; n_rd = rd; n_rs = rs; n_rt = rt;
    endtask

    task automatic run_instr(input logic [4:0] op, input logic [2:0] rd,
                             input logic [2:0] rs, input logic [2:0] rt);
        int k;
        set_id(op, rd, rs, rt);
        n_fl = 0;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!m_admit && k < 20);
        if (!m_admit) chk("admit_timeout", 0, 1);
        n_v = 0;
    endtask

    task automatic idle(input int k);
        n_v = 0; n_fl = 0; n_mr = 1;
        for (int i = 0; i < k; i++) cycle();
    endtask

    function automatic logic [4:0] pick_op();
        case ($urandom % 16)
            0: return 5'b00001;  1: return 5'b01000;  2: return 5'b01001;
            3: return 5'b01010;  4: return 5'b01011;  5: return 5'b10100;
            6: return 5'b10111;  7: return 5'b10000;  8: return 5'b10001;
            9: return 5'b10011; 10: return 5'b11001; 11: return 5'b11011;
            12: return 5'b10001; 13: return 5'b11111; 14: return 5'b01100;
            default: return ($urandom % 40 == 0) ? 5'b00000 : 5'b10001;
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        id_valid = 0; flush = 0; mem_ready = 1;
        id_op = 0; id_rd = 0; id_rs = 0; id_rt = 0;
        model_clear();

        // ADDI rd=3
        do_reset();
        run_instr(5'b01000, 3'd3, 3'd1, 3'd0);
        idle(4);
        chk("addi_drained", sb.size(), 0);

        // LD r2 then ADD using r2: single load-use bubble
        do_reset();
        run_instr(5'b10001, 3'd2, 3'd5, 3'd0);
        run_instr(5'b11011, 3'd1, 3'd2, 3'd4);
        idle(4);
        #2;
        chk("lu_stall_cnt", 32'(stall_cnt), 1);

        // ST held in MEM for 3 cycles
        do_reset();
        run_instr(5'b10000, 3'd0, 3'd1, 3'd2);
        n_mr = 1; cycle();
        n_mr = 0; for (int i = 0; i < 3; i++) cycle();
        idle(4);
        #2;
        chk("freeze_stall_cnt", 32'(stall_cnt), 3);

        // flush kills SUBI in ID, next instruction admitted after
        do_reset();
        set_id(5'b01001, 3'd4, 3'd1, 3'd0);
        n_fl = 1; n_mr = 1;
        cycle();
        chk("flush_no_admit", 32'(m_admit), 0);
        run_instr(5'b01000, 3'd5, 3'd1, 3'd0);
        idle(4);

        // illegal opcode then normal flow
        do_reset();
        run_instr(5'b11111, 3'd6, 3'd0, 3'd0);
        run_instr(5'b01010, 3'd7, 3'd1, 3'd0);
        idle(4);
        #2;
        chk("illegal_sticky", 32'(illegal), 1);

        // reset arriving during a freeze
        do_reset();
        run_instr(5'b10000, 3'd0, 3'd1, 3'd2);
        n_mr = 1; cycle();
        n_mr = 0; cycle(); cycle();
        #2;
        rst = 1'b0;
        #1;
        check_reset_state();
        model_clear();
        n_mr = 1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        idle(3);

        // freeze of 5 cycles, then HALT; ADDI behind it never enters
        do_reset();
        run_instr(5'b10000, 3'd0, 3'd1, 3'd2);
        n_mr = 1; cycle();
        n_mr = 0; for (int i = 0; i < 5; i++) cycle();
        n_mr = 1;
        run_instr(5'b00000, 3'd0, 3'd0, 3'd0);
        set_id(5'b01000, 3'd3, 3'd1, 3'd0);
        for (int i = 0; i < 6; i++) cycle();
        #2;
        chk("halt_halted", 32'(halted), 1);
        chk("halt_stall_if", 32'(stall_if), 1);
        chk("halt_cnt", 32'(stall_cnt), 5);
        chk("halt_sat_cnt", 32'(s_stall_cnt), 3);
        chk("halt_drained", sb.size(), 0);

        // randomized episodes
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                if (!n_v || m_admit || (n_fl && !m_frz)) begin
                    n_v  = ($urandom % 4) != 0;
                    n_op = pick_op();
                    n_rd = 3'($urandom % 4);
                    n_rs = 3'($urandom % 4);
                    n_rt = 3'($urandom % 4);
                end
                if (!(n_fl && m_frz)) n_fl = ($urandom % 10) == 0;
                n_mr = ($urandom % 10) < 7;
                cycle();
                if (m_halted) break;
            end
            n_mr = 1;
            n_fl = n_fl && m_frz;
            n_v  = 0;
            cycle();
            idle(5);
            chk("ep_drained", sb.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
